cpu_trace_buffer: RTL
=====================

# cpu_trace_buffer

Parametrised on-chip execution trace recorder for the 19-bit CPU. It captures per-cycle pc, instruction and result samples into a circular buffer of configurable depth, with one-shot, continuous-wrap and pc-trigger modes. It then streams the captured entries out oldest-first over a valid/ready port. It sits beside `cpu` on its debug outputs and replaces fixed-length cycle printing with a synthesizable, depth-independent capture.

## Interface
- `PC_W`, default 19, pc sample width
- `INSTR_W`, default 19, instruction sample width
- `DATA_W`, default 19, result sample width
- `DEPTH`, default 16, number of entries; a power of two, ≥2
- `CNT_W`, default `$clog2(DEPTH)+1`, width of `count_out`

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `sample_en`  in  1  current `pc_in`/`instr_in`/`result_in` form a valid sample this cycle
- `pc_in`  in  PC_W  sampled pc
- `instr_in`  in  INSTR_W  sampled instruction
- `result_in`  in  DATA_W  sampled result
- `arm`  in  1  start a capture; honoured only in IDLE
- `mode`  in  1  0 = one-shot (stop when full), 1 = circular (overwrite oldest); latched on `arm`
- `trig_en`  in  1  1 = wait for `pc_in == trig_pc` before capturing; latched on `arm`
- `trig_pc`  in  PC_W  trigger pc; latched on `arm`
- `stop`  in  1  end capture in WAIT_TRIG or CAPTURE
- `rd_valid`  out  1  readout entry present
- `rd_ready`  in  1  consumer accepts entry
- `rd_pc`  out  PC_W  entry pc
- `rd_instr`  out  INSTR_W  entry instruction
- `rd_result`  out  DATA_W  entry result
- `rd_last`  out  1  current entry is the final one
- `count_out`  out  CNT_W  entries held, saturating at DEPTH
- `overflow_out`  out  1  at least one entry overwritten in circular mode
- `state_out`  out  2  IDLE=0, WAIT_TRIG=1, CAPTURE=2, READOUT=3

## Operation
- IDLE: `arm` clears `wr_ptr`, `count`, `overflow` and latches `mode`, `trig_en`, `trig_pc`. Next state is WAIT_TRIG if `trig_en`, otherwise CAPTURE.
- WAIT_TRIG: `sample_en && pc_in==trig_pc` writes that sample as entry 0 and moves to CAPTURE. `stop` returns to IDLE with count 0.
- CAPTURE: each `sample_en` writes to `mem[wr_ptr]`; `wr_ptr` wraps modulo DEPTH.
  - One-shot: the write that brings `count` to DEPTH also moves the state to READOUT.
  - Circular: once full, every write overwrites the oldest entry and sets `overflow`; `count` stays at DEPTH.
  - `stop` moves to READOUT, or to IDLE if `count`==0. A `sample_en` in the same cycle is written first and included.
- READOUT:
  - `rd_ptr` starts at `wr_ptr` if `overflow`, else 0.
  - `rd_valid`=1; `rd_*` = `mem[rd_ptr]`.
  - Each handshake (`rd_valid && rd_ready`) advances `rd_ptr` and decrements the remaining count.
  - `rd_last`=1 when the remaining count is 1; the handshake on that entry returns the state to IDLE.
  - `sample_en`, `arm` and `stop` are ignored.
- `arm` outside IDLE is ignored. The trigger compare runs only in WAIT_TRIG.
- Reset (any state, any time): state IDLE, pointers 0, `count_out`=0, `overflow_out`=0, `rd_valid`=0, `rd_last`=0, `rd_pc`/`rd_instr`/`rd_result`=0. Memory contents are don't-care. Reset wins over all inputs.

## Timing
- Write latency 1: a sample presented with `sample_en` at edge N is stored, and `count_out` updated, after edge N.
- `arm` at edge N: `state_out` changes after edge N. The first sample captured is at edge N+1 or later.
- Readout: `rd_valid` is high the cycle after the transition edge into READOUT. One entry per cycle when `rd_ready` is held high, so DEPTH entries drain in DEPTH cycles.
- `rd_*` outputs are stable while `rd_valid && !rd_ready`; `rd_valid` never drops without a handshake.
- After the last handshake, `rd_valid`=0 and the state is IDLE the next cycle. A new `arm` is accepted from then on.

## Configuration
- `TRACE_RESULT_EN` defined: the result field is stored and `rd_result` carries it.
- `TRACE_RESULT_EN` undefined: no result storage; `rd_result` is tied to 0; the entry width is PC_W+INSTR_W. All other behaviour is identical.

## Test plan
- DEPTH=4, one-shot, no trigger; `arm`, then samples pc=0..5 → readout pc 0,1,2,3; `rd_last` on pc 3; `overflow_out`=0; IDLE afterwards.
- Circular mode; samples pc=0..5, then `stop` → readout pc 2,3,4,5; `overflow_out`=1; `count_out`=4.
- `trig_en`=1, `trig_pc`=3, one-shot; samples pc=0..7 → readout pc 3,4,5,6; `state_out`=1 until the pc=3 sample.
- Circular mode; `stop` with no samples → `rd_valid` never asserts; IDLE the next cycle; `count_out`=0. Separately, `stop` in the same cycle as a pc=9 sample → pc 9 is the last entry read.
- Backpressure: `rd_ready` low for 3 cycles mid-readout → `rd_valid` held and `rd_pc`/`rd_instr` unchanged; no entry lost or duplicated.
- `reset` asserted after 2 captured samples → every output at its reset value immediately. Without `TRACE_RESULT_EN`, `rd_result`=0 throughout readout.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular pc/instr/result trace capture with oldest-first valid/ready readout
// Ports: clk, reset (async, active-high); sample_en/pc_in/instr_in/result_in sample input;
//   arm/mode/trig_en/trig_pc/stop capture control; rd_valid/rd_ready/rd_pc/rd_instr/rd_result/rd_last
//   readout stream; count_out/overflow_out/state_out status.
// Macro TRACE_RESULT_EN: store the result field; otherwise rd_result is tied to 0.
module cpu_trace_buffer #(
  parameter int PC_W = 19,
  parameter int INSTR_W = 19,
  parameter int DATA_W = 19,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_en,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [DATA_W-1:0]  result_in,
  input  logic               arm,
  input  logic               mode,
  input  logic               trig_en,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic               stop,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [PC_W-1:0]    rd_pc,
  output logic [INSTR_W-1:0] rd_instr,
  output logic [DATA_W-1:0]  rd_result,
  output logic               rd_last,
  output logic [CNT_W-1:0]   count_out,
  output logic               overflow_out,
  output logic [1:0]         state_out
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT_TRIG = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] READOUT = 2'd3;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
`ifdef TRACE_RESULT_EN
  localparam int EW = PC_W + INSTR_W + DATA_W;
`else
  localparam int EW = PC_W + INSTR_W;
`endif
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wr_entry, rd_entry;
  logic [1:0] state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, rem_q, rem_d;
  logic overflow_q, overflow_d, mode_q, mode_d, trig_en_q, trig_en_d;
  logic [PC_W-1:0] trig_pc_q, trig_pc_d;
  logic we;
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d = count_q;
    rem_d = rem_q;
    overflow_d = overflow_q;
    mode_d = mode_q;
    trig_en_d = trig_en_q;
    trig_pc_d = trig_pc_q;
    we = 1'b0;
    case (state_q)
      IDLE: if (arm) begin
        wr_ptr_d = '0;
        count_d = '0;
        overflow_d = 1'b0;
        mode_d = mode;
        trig_en_d = trig_en;
        trig_pc_d = trig_pc;
        state_d = trig_en ? WAIT_TRIG : CAPTURE;
      end
      WAIT_TRIG: if (stop) state_d = IDLE;
      else if (sample_en && pc_in == trig_pc_q) begin
        we = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d = CNT_W'(1);
        state_d = CAPTURE;
      end
      CAPTURE: begin
        we = sample_en;
        if (sample_en) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          overflow_d = overflow_q | (count_q == FULL);
          count_d = (count_q == FULL) ? count_q : count_q + 1'b1;
        end
        // the same-cycle sample is already folded into count_d/wr_ptr_d before leaving
        if ((!mode_q && count_d == FULL) || stop) begin
          state_d = (count_d == '0) ? IDLE : READOUT;
          rd_ptr_d = overflow_d ? wr_ptr_d : '0;
          rem_d = count_d;
        end
      end
      default: if (rd_ready) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        rem_d = rem_q - 1'b1;
        state_d = (rem_q == CNT_W'(1)) ? IDLE : READOUT;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      rem_q <= '0;
      overflow_q <= 1'b0;
      mode_q <= 1'b0;
      trig_en_q <= 1'b0;
      trig_pc_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      rem_q <= rem_d;
      overflow_q <= overflow_d;
      mode_q <= mode_d;
      trig_en_q <= trig_en_d;
      trig_pc_q <= trig_pc_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= wr_entry;
  end
  assign rd_entry = mem[rd_ptr_q];
  assign rd_valid = state_q == READOUT;
  assign rd_last = rd_valid && rem_q == CNT_W'(1);
  assign rd_pc = rd_valid ? rd_entry[EW-1 -: PC_W] : '0;
  assign rd_instr = rd_valid ? rd_entry[EW-PC_W-1 -: INSTR_W] : '0;
`ifdef TRACE_RESULT_EN
  assign wr_entry = {pc_in, instr_in, result_in};
  assign rd_result = rd_valid ? rd_entry[DATA_W-1:0] : '0;
`else
  logic unused_result;
  assign unused_result = ^result_in;
  assign wr_entry = {pc_in, instr_in};
  assign rd_result = '0;
`endif
  assign count_out = count_q;
  assign overflow_out = overflow_q;
  assign state_out = state_q;
endmodule
